clock_supervisor: RTL
=====================

Name: clock_supervisor

Overview:
- Parametrised supervisor for NUM_PLL clock generators (PLL/MMCM wrappers) in the clocking layer.
- Runs on a free-running reference clock. Sequences generator resets, waits for and qualifies lock on all generators, and releases a system reset only when every clock is stable.
- Detects lock loss and retries a bounded number of times before latching a fault.
- Replaces fixed single-PLL wrappers that expose raw lock with no sequencing or recovery.

Parameters:
- NUM_PLL, 1, number of supervised generators (1..16).
- RST_HOLD_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 65536, maximum cycles in WAIT_LOCK before an attempt fails (>=2).
- LOCK_STABLE_CYCLES, 64, consecutive cycles with all locks high required before RUN (>=1).
- MAX_RETRIES, 3, failed attempts tolerated before FAULT.
- SYNC_STAGES, 2, flip-flop stages on each pll_locked input (>=2).

Ports:
- clk, in, 1, free-running reference clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- enable, in, 1, run supervision; low forces IDLE.
- pll_locked, in, NUM_PLL, raw lock indicators, asynchronous to clk.
- pll_rst, out, NUM_PLL, generator reset, active-high.
- sys_rst, out, 1, downstream reset, active-high.
- clk_ok, out, 1, all clocks locked and qualified.
- fault, out, 1, retries exhausted.
- lock_lost, out, 1, one-cycle pulse on lock loss while in RUN.
- locked_sync, out, NUM_PLL, synchronised lock vector.
- retry_count, out, 8, failed attempts in the current sequence.
- lock_loss_count, out, 8, saturating count of RUN lock losses.
- state, out, 3, encoding: IDLE=0, RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.

Behaviour:
- Reset (rst_n low, async) values:
  - state=IDLE, pll_rst=all 1, sys_rst=1.
  - clk_ok=0, fault=0, lock_lost=0.
  - counters 0, synchronisers 0.
- All outputs are registered.
- locked_sync lags pll_locked by SYNC_STAGES cycles. all_locked = AND of locked_sync.
- One shared cycle counter, cleared on every state entry.
- enable low in any state: next state IDLE, retry_count cleared, lock_loss_count kept. This takes priority over all other transitions.
- IDLE:
  - pll_rst=1, sys_rst=1, clk_ok=0.
  - enable high -> RESET.
- RESET:
  - pll_rst=1 for exactly RST_HOLD_CYCLES cycles, then -> WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0.
  - all_locked -> STABLE.
  - Else, when the counter reaches LOCK_TIMEOUT_CYCLES-1: if retry_count<MAX_RETRIES, increment retry_count and -> RESET; otherwise -> FAULT.
  - Simultaneous all_locked and timeout: all_locked wins.
- STABLE:
  - pll_rst=0, sys_rst still 1.
  - all_locked low on any cycle -> WAIT_LOCK with a fresh timeout.
  - Counter reaching LOCK_STABLE_CYCLES-1 with all_locked high -> RUN; retry_count cleared on entry to RUN.
- RUN:
  - clk_ok=1, sys_rst=0, starting the first cycle state=RUN.
  - all_locked low -> RESET next cycle. In that same next cycle: lock_lost=1, clk_ok=0, sys_rst=1, lock_loss_count +1 (saturates at 255). retry_count unchanged.
- FAULT:
  - fault=1, pll_rst=all 1, sys_rst=1, clk_ok=0.
  - Exit only via enable low (fault clears in IDLE) or rst_n.
- retry_count saturates at 255.
- Glitches on pll_locked shorter than one clk period are not guaranteed to be seen.

Test Plan:
- Normal bring-up: NUM_PLL=2, RST_HOLD=16, STABLE=64; enable=1, both locks rise 100 cycles after pll_rst falls.
  - pll_rst high exactly 16 cycles.
  - clk_ok=1 and sys_rst=0 at 100+SYNC_STAGES+64(+1 for the RUN transition) cycles after pll_rst falls.
  - retry_count=0.
- Timeout retry to fault: LOCK_TIMEOUT=100, MAX_RETRIES=3, locks held low.
  - Exactly 4 RESET pulses of 16 cycles each, retry_count reaches 3.
  - Then fault=1 and state=5; enable low -> fault=0, state=0.
- Stability glitch: one lock drops for 3 cycles at cycle 30 of STABLE.
  - Returns to WAIT_LOCK, then requalifies a full 64 cycles.
  - clk_ok never asserted during the glitch.
- Lock loss in RUN: drop pll_locked[1].
  - lock_lost pulses once, exactly 1 cycle.
  - sys_rst=1, clk_ok=0, lock_loss_count=1, state=RESET.
  - Restores to RUN when lock returns.
- Async reset mid-WAIT_LOCK: assert rst_n low.
  - All outputs at reset values immediately, without waiting for a clk edge.
- Simultaneous lock and timeout in the final WAIT_LOCK cycle -> STABLE, retry_count unchanged.

Source files
------------

// File: rtl/clock_supervisor.sv
// Clock supervisor: sequences resets for NUM_PLL clock generators, qualifies
// their lock indicators, releases the system reset once every clock is stable,
// and retries a bounded number of times before latching a fault.
module clock_supervisor #(
    parameter int unsigned NUM_PLL             = 1,
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 64,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned SYNC_STAGES         = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_PLL-1:0] pll_locked,
    output logic [NUM_PLL-1:0] pll_rst,
    output logic               sys_rst,
    output logic               clk_ok,
    output logic               fault,
    output logic               lock_lost,
    output logic [NUM_PLL-1:0] locked_sync,
    output logic [7:0]         retry_count,
    output logic [7:0]         lock_loss_count,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReset    = 3'd1,
        StWaitLock = 3'd2,
        StStable   = 3'd3,
        StRun      = 3'd4,
        StFault    = 3'd5
    } state_e;

    // The shared counter only ever has to reach the largest of the three intervals.
    localparam int unsigned MaxAB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CntMax = (MaxAB > LOCK_STABLE_CYCLES) ? MaxAB : LOCK_STABLE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] RstLast     = CntW'(RST_HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [7:0]          retry_q, retry_d;
    logic [7:0]          loss_q, loss_d;
    logic                lost_d;
    logic [NUM_PLL-1:0]  sync_q [SYNC_STAGES];
    logic                all_locked;

    assign locked_sync     = sync_q[SYNC_STAGES-1];
    assign all_locked      = &sync_q[SYNC_STAGES-1];
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;
    assign state           = state_q;

    // Multi-stage synchroniser bringing the asynchronous lock indicators into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pll_locked;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Next-state, retry and lock-loss bookkeeping; enable low overrides everything.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        lost_d  = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StReset;
                StReset: begin
                    if (cnt_q == RstLast) state_d = StWaitLock;
                end
                StWaitLock: begin
                    // A lock seen on the last timeout cycle still counts as success.
                    if (all_locked) begin
                        state_d = StStable;
                    end else if (cnt_q == TimeoutLast) begin
                        if (32'(retry_q) < MAX_RETRIES) begin
                            retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                            state_d = StReset;
                        end else begin
                            state_d = StFault;
                        end
                    end
                end
                StStable: begin
                    if (!all_locked) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                        retry_d = '0;
                    end
                end
                StRun: begin
                    if (!all_locked) begin
                        state_d = StReset;
                        lost_d  = 1'b1;
                        loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                    end
                end
                StFault: state_d = StFault;
                default: state_d = StIdle;
            endcase
        end
    end

    // Shared interval counter: restarts on every state entry, idles where unused.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {StReset, StWaitLock, StStable}) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // State register with outputs decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            lock_lost <= 1'b0;
            pll_rst   <= '1;
            sys_rst   <= 1'b1;
            clk_ok    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            lock_lost <= lost_d;
            if (state_d inside {StIdle, StReset, StFault}) pll_rst <= '1;
            else                                           pll_rst <= '0;
            sys_rst   <= (state_d != StRun);
            clk_ok    <= (state_d == StRun);
            fault     <= (state_d == StFault);
        end
    end

endmodule
